// File: rtl/adc_fill_sequencer_pkg.sv
// adc_fill_sequencer_pkg: shared state encoding and width defaults for the fill sequencer.
package adc_fill_sequencer_pkg;
   localparam int LEN_W_DEF   = 23;
   localparam int HOLD_W_DEF  = 16;
   localparam int TRIG_LOST_W = 16;
   typedef enum logic [2:0] {IDLE, ARMED, ACQ, DONE, HOLDOFF} state_e;
endpackage

// File: rtl/adc_fill_sequencer_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus registered rising-edge detector for async levels.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);
   logic [1:0] sync_q;
   logic       dly_q;
   logic       rise_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], async_i};
         dly_q  <= sync_q[1];
         rise_q <= sync_q[1] & ~dly_q;
      end
   end
   assign rise_o = rise_q;
endmodule

// File: rtl/adc_fill_sequencer.sv
// adc_fill_sequencer: turns an async fill trigger into a gated acquisition window,
// one end-of-fill strobe and a post-fill holdoff, counting rejected trigger edges.
module adc_fill_sequencer
   import adc_fill_sequencer_pkg::*;
#(
   parameter int LEN_W  = LEN_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF,
   parameter int LOST_W = TRIG_LOST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig_i,
   input  logic              arm_i,
   input  logic [LEN_W-1:0]  fill_len_i,
   input  logic [HOLD_W-1:0] holdoff_len_i,
   output logic              acq_en_o,
   output logic [LEN_W-1:0]  sample_idx_o,
   output logic              fill_done_o,
   output logic              busy_o,
   output logic [LOST_W-1:0] trig_lost_o
);
   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hcnt_q, hcnt_d;
   logic [LOST_W-1:0] lost_q, lost_d;
   logic              acq_q, acq_d, done_q, done_d, busy_q, busy_d;
   logic              rise, accept, acq_last, hold_last;

   sync_edge_det u_trig (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(trig_i),
      .rise_o (rise)
   );

   assign accept    = (state_q == ARMED) && arm_i && rise;
   assign acq_last  = idx_q == len_q - LEN_W'(1);
   assign hold_last = hcnt_q == hold_q - HOLD_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = arm_i ? ARMED : IDLE;
         ARMED:   state_d = !arm_i ? IDLE : !rise ? ARMED : (fill_len_i == '0) ? DONE : ACQ;
         ACQ:     state_d = acq_last ? DONE : ACQ;
         DONE:    state_d = (hold_q != '0) ? HOLDOFF : arm_i ? ARMED : IDLE;
         HOLDOFF: state_d = !hold_last ? HOLDOFF : arm_i ? ARMED : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the next state so they come straight out of flops.
   always_comb begin
      acq_d  = state_d == ACQ;
      done_d = state_d == DONE;
      busy_d = (state_d == ACQ) || (state_d == DONE) || (state_d == HOLDOFF);
   end

   always_comb begin
      len_d  = accept ? fill_len_i : len_q;
      hold_d = accept ? holdoff_len_i : hold_q;
      idx_d  = accept ? '0 : (state_q == ACQ && !acq_last) ? idx_q + LEN_W'(1) : idx_q;
      hcnt_d = (state_q == DONE) ? '0 : (state_q == HOLDOFF) ? hcnt_q + HOLD_W'(1) : hcnt_q;
      lost_d = (rise && !accept && lost_q != '1) ? lost_q + LOST_W'(1) : lost_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q  <= '0;
         hold_q <= '0;
         idx_q  <= '0;
         hcnt_q <= '0;
         lost_q <= '0;
         acq_q  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         len_q  <= len_d;
         hold_q <= hold_d;
         idx_q  <= idx_d;
         hcnt_q <= hcnt_d;
         lost_q <= lost_d;
         acq_q  <= acq_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   assign acq_en_o     = acq_q;
   assign sample_idx_o = idx_q;
   assign fill_done_o  = done_q;
   assign busy_o       = busy_q;
   assign trig_lost_o  = lost_q;
endmodule

// File: doc/adc_fill_sequencer.md
# adc_fill_sequencer

Per-channel fill acquisition sequencer that converts an asynchronous fill trigger into a gated sample-acquisition window of programmable length. It then emits a one-cycle end-of-fill strobe. It sits directly upstream of the fill-number counter: `fill_done` drives that counter's `enable`, so exactly one pulse is issued per completed fill. It also supplies the sample-write enable and sample index to the channel's waveform buffer.

## Interface
- `LEN_W`, default 23: width of fill length and sample index.
- `HOLD_W`, default 16: width of the post-fill holdoff count.
- `clk` in, 1: ADC-domain clock; all logic is in this domain.
- `rst_n` in, 1: synchronous active-low reset.
- `trig` in, 1: fill trigger, asynchronous level. Rising edge starts a fill.
- `arm` in, 1: level; high permits triggers to be accepted.
- `fill_len` in, LEN_W: samples per fill; latched on trigger acceptance.
- `holdoff_len` in, HOLD_W: dead cycles after each fill; latched on trigger acceptance.
- `acq_en` out, 1: sample-write enable to the waveform buffer.
- `sample_idx` out, LEN_W: index of the current sample, valid when `acq_en` is high.
- `fill_done` out, 1: one-cycle strobe at end of fill (the fill counter's enable).
- `busy` out, 1: high in ACQ, DONE, HOLDOFF.
- `trig_lost` out, 16: count of rejected trigger edges; saturates at 0xFFFF.

## Operation
- Trigger path: 2-flop synchronizer, then one delay flop. `trig_rise = sync & ~dly`. Only rising edges count; a held-high `trig` produces one edge.
- States:
  - IDLE: `arm=1` goes to ARMED next cycle.
  - ARMED:
    - `arm=0` goes to IDLE.
    - `trig_rise` latches `fill_len` and `holdoff_len`, clears `sample_idx`, and goes to ACQ.
    - If the latched `fill_len==0`, it goes to DONE instead (zero-sample fill; `fill_done` still pulses).
  - ACQ:
    - `acq_en=1` every cycle.
    - `sample_idx` increments each cycle from 0.
    - On the cycle where `sample_idx == len-1`, it goes to DONE.
  - DONE:
    - `fill_done=1` for this single cycle.
    - If holdoff is 0, it goes to ARMED when `arm=1`, otherwise IDLE.
    - If holdoff is nonzero, it goes to HOLDOFF.
  - HOLDOFF:
    - Counts `holdoff_len` cycles.
    - Then goes to ARMED if `arm=1`, otherwise IDLE.
- `arm` deasserted mid-fill does not abort. ACQ, DONE and HOLDOFF complete, then the block goes to IDLE.
- `trig_rise` in any state other than ARMED increments `trig_lost`, saturating. This includes IDLE.
- `trig_rise` coincident with the last HOLDOFF cycle or with DONE→ARMED is lost, not queued.
- Changes to `fill_len` or `holdoff_len` during a fill have no effect until the next acceptance.
- Reset:
  - State IDLE.
  - `acq_en`, `fill_done`, `busy` = 0.
  - `sample_idx` = 0, `trig_lost` = 0.
  - Reset mid-ACQ terminates the fill with no `fill_done`.

## Timing
- All outputs are registered.
- Latency:
  - `trig` rises before edge k.
  - Sync output is high at k+1; `trig_rise` is high at k+2.
  - The state register enters ACQ and `acq_en` goes high at k+3.
- `acq_en` is high for exactly `fill_len` consecutive cycles, with `sample_idx` running 0…`fill_len`-1.
- `fill_done` is high in the cycle immediately after the last `acq_en` cycle. `acq_en` and `fill_done` are never high together.
- `busy` rises with `acq_en` (or with `fill_done` for zero-length fills). It falls in the first ARMED/IDLE cycle after HOLDOFF.
- Minimum trigger-to-trigger spacing for no loss: `fill_len` + 1 + `holdoff_len` + 1 cycles after acceptance.

## Structure
- A shared package holds:
  - the state enum (IDLE, ARMED, ACQ, DONE, HOLDOFF);
  - `LEN_W`/`HOLD_W` defaults;
  - the `trig_lost` width constant.
- One sub-module, `sync_edge_det`: 2-flop synchronizer plus rising-edge detector, reset to 0 by `rst_n`. It is reused for other async strobes in the channel.
- The FSM, counters and saturation logic live in the top module.

## Test plan
- Basic fill:
  - Stimulus: `arm=1`, `fill_len=5`, `holdoff_len=0`, a single `trig` pulse.
  - Required: `acq_en` high 5 cycles starting 3 cycles after sampling, with `sample_idx` 0,1,2,3,4. Then exactly one `fill_done` cycle, then ARMED.
- Zero length:
  - Stimulus: `fill_len=0` and a trigger.
  - Required: no `acq_en`, one `fill_done` pulse, `busy` high 1 cycle.
- Lost triggers:
  - Stimulus: `fill_len=100`, `holdoff_len=10`, triggers 20 and 105 cycles after the first.
  - Required: `trig_lost=2`, one `fill_done`.
  - Also force 0x10002 edges while in IDLE; required: `trig_lost=0xFFFF`.
- Disarm mid-fill:
  - Stimulus: `arm` drops at `sample_idx=3` of `fill_len=8`.
  - Required: all 8 samples complete, `fill_done` pulses, then IDLE. A later trigger increments `trig_lost`.
- Reset mid-ACQ:
  - Stimulus: `rst_n=0` for 1 cycle at `sample_idx=2`.
  - Required: next cycle all outputs 0, no `fill_done`, state IDLE.
- Back-to-back:
  - Stimulus: `holdoff_len=0`, `fill_len=4`, trigger held high for 50 cycles, then toggled at the minimum spacing.
  - Required: one fill per rising edge, none lost, and the `fill_done` count equals the edge count.
